grant_mux: RTL

Packet-level data mux that sits directly downstream of the round-robin arbiter. It presents the `valid` bits of N requester streams to the arbiter as requests and latches the one-hot grant it returns. It then routes the granted stream's beats, with valid/ready handshake, into a registered 2-entry output buffer until that stream's `last` beat has been accepted. Arbitration happens only at packet boundaries, so packets never interleave.

---
 rtl/grant_mux_pkg.sv | 24 ++
 rtl/stream_skid_buffer.sv | 62 ++++++
 rtl/grant_mux.sv | 100 ++++++++++
 3 files changed

// File: rtl/grant_mux_pkg.sv
// grant_mux shared types and helpers.
// Used by the top-level mux and its output buffer.
package grant_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Lowest set bit wins, so a malformed multi-bit vector still maps cleanly.
    function automatic int onehot_to_index(input logic [63:0] onehot);
        int idx;
        idx = 0;
        for (int i = 63; i >= 0; i--) begin
            if (onehot[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry registered output FIFO with a registered full flag.
// Head register drives the output directly.
module stream_skid_buffer
    import grant_mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic             pop;

    assign valid = (count_q != 2'd0);
    assign full  = (count_q == 2'd2);
    assign data  = head_q;
    assign pop   = valid & ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= push_data;
                    else                 tail_q <= push_data;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new beat lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        head_q <= push_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) push |-> !full
    );

endmodule

// File: rtl/grant_mux.sv
// Packet-level mux behind a round-robin arbiter.
// Locks onto one granted stream until its last beat is accepted.
module grant_mux
    import grant_mux_pkg::*;
#(
    parameter  int REQUEST_WIDTH = 2,
    parameter  int DATA_WIDTH    = 32,
    localparam int INDEX_WIDTH   = index_width(REQUEST_WIDTH)
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic [REQUEST_WIDTH-1:0]                   i_valid,
    output logic [REQUEST_WIDTH-1:0]                   o_ready,
    input  logic [REQUEST_WIDTH-1:0][DATA_WIDTH-1:0]   i_data,
    input  logic [REQUEST_WIDTH-1:0]                   i_last,
    output logic [REQUEST_WIDTH-1:0]                   o_request,
    input  logic [REQUEST_WIDTH-1:0]                   i_grant,
    output logic                                       o_valid,
    input  logic                                       i_ready,
    output logic [DATA_WIDTH-1:0]                      o_data,
    output logic                                       o_last,
    output logic [INDEX_WIDTH-1:0]                     o_source
);

    localparam int N  = REQUEST_WIDTH;
    localparam int BW = DATA_WIDTH + 1 + INDEX_WIDTH;

    state_t                 state_q;
    logic [N-1:0]           lock_q;
    logic [N-1:0]           grant_ok;
    logic [N-1:0]           grant_pick;
    logic [N-1:0]           take;
    logic [INDEX_WIDTH-1:0] sel;
    logic                   xfer;
    logic                   xfer_last;
    logic                   buf_full;
    logic [BW-1:0]          push_data;
    logic [BW-1:0]          buf_data;

    assign grant_ok   = i_grant & i_valid;
    assign grant_pick = grant_ok & (~grant_ok + N'(1));
    assign sel        = INDEX_WIDTH'(onehot_to_index(64'(lock_q)));

    assign o_request = (state_q == IDLE) ? i_valid : '0;
    assign o_ready   = (state_q == LOCKED) ? (lock_q & {N{~buf_full}}) : '0;

    assign take      = i_valid & o_ready;
    assign xfer      = |take;
    assign xfer_last = xfer & i_last[sel];
    assign push_data = {i_data[sel], i_last[sel], sel};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            lock_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|grant_ok) begin
                        lock_q  <= grant_pick;
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer_last) begin
                        lock_q  <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    stream_skid_buffer #(
        .WIDTH(BW)
    ) u_buf (
        .clk      (i_clk),
        .rst      (i_rst),
        .push     (xfer),
        .push_data(push_data),
        .full     (buf_full),
        .valid    (o_valid),
        .ready    (i_ready),
        .data     (buf_data)
    );

    assign {o_data, o_last, o_source} = buf_data;

    a_grant_onehot: assert property (
        @(posedge i_clk) disable iff (i_rst)
        (state_q == IDLE && |o_request) |-> $onehot0(i_grant)
    );

    a_lock_onehot: assert property (
        @(posedge i_clk) disable iff (i_rst)
        (state_q == LOCKED) |-> $onehot(lock_q)
    );

endmodule
